// File: rtl/mem_io_responder_pkg.sv
// Shared address-map constants and access classification for the memory/IO responder.
package mem_io_responder_pkg;

   localparam logic [1:0]  IO_SEL      = 2'b11;
   localparam logic [17:0] IO_BASE     = {IO_SEL, 16'h0000};
   localparam logic [17:0] IO_UART     = 18'h30000;
   localparam logic [17:0] IO_CLK_STOP = 18'h30004;
   localparam logic [17:0] RAM_LIMIT   = 18'h20000;

   typedef enum logic [2:0] {
      ACC_RAM,
      ACC_OOB,
      ACC_UART,
      ACC_CNT0,
      ACC_CNT_HI,
      ACC_IO_NONE
   } acc_t;

   // ACC_OOB is only a hint; the top decides whether it aliases into RAM or faults.
   function automatic acc_t decode(input logic [17:0] a);
      acc_t kind;
      if ((a & IO_BASE) != IO_BASE) begin
         if (a >= RAM_LIMIT) kind = ACC_OOB;
         else                kind = ACC_RAM;
      end else if (a == IO_UART) begin
         kind = ACC_UART;
      end else if (a == IO_CLK_STOP) begin
         kind = ACC_CNT0;
      end else if (a[17:2] == IO_CLK_STOP[17:2]) begin
         kind = ACC_CNT_HI;
      end else begin
         kind = ACC_IO_NONE;
      end
      return kind;
   endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Parameterised-depth 8-bit synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module byte_fifo #(
   parameter int DEPTH_BITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [7:0]            push_data,
   input  logic                  pop,
   output logic [7:0]            head,
   output logic [DEPTH_BITS:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_BITS:0]   CNT_ONE = 1;
   localparam logic [DEPTH_BITS:0]   CNT_FULL = DEPTH;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// Bus target: 128 KB byte RAM plus UART/counter/stop I/O window at 0x30000.
// Define MEM_IO_BOUNDS_CHECK_EN to fault accesses in 0x20000-0x2FFFF instead of aliasing them.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int ADDR_BITS     = 17,
   parameter int TX_DEPTH_BITS = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        program_stop,
   output logic        tx_overflow,
   output logic        bus_err
);

   localparam logic [TX_DEPTH_BITS:0] NEAR_FULL = (1 << TX_DEPTH_BITS) - 1;

   logic [7:0]               ram [0:(1 << ADDR_BITS) - 1];
   logic [17:0]              addr;
   acc_t                     acc;
   logic                     oob;
   logic                     is_ram;
   logic                     ram_we;
   logic [31:0]              cycle_cnt;
   logic [31:8]              cnt_snap;
   logic                     fifo_push;
   logic [7:0]               fifo_push_data;
   logic                     fifo_pop;
   logic [TX_DEPTH_BITS:0]   fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     addr_hi_unused;

   assign addr           = mem_a[17:0];
   assign addr_hi_unused = ^mem_a[31:18];
   assign acc            = decode(addr);

`ifdef MEM_IO_BOUNDS_CHECK_EN
   assign oob = (acc == ACC_OOB);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)             bus_err <= 1'b0;
      else if (rdy_in && oob)  bus_err <= 1'b1;
   end
`else
   assign oob     = 1'b0;
   assign bus_err = 1'b0;
`endif

   assign is_ram = ((acc == ACC_RAM) || (acc == ACC_OOB)) && !oob;
   assign ram_we = rdy_in && mem_wr && is_ram;

   // rx_pop is combinational so the UART sees the consume in the access cycle itself.
   assign rx_pop = rst_in && rdy_in && !mem_wr && (acc == ACC_UART) && rx_valid;

   assign fifo_push      = rdy_in && mem_wr &&
                           (((acc == ACC_UART) && (cpu_dout != 8'h00)) || (acc == ACC_CNT0));
   assign fifo_push_data = (acc == ACC_CNT0) ? 8'h00 : cpu_dout;
   assign fifo_pop       = tx_valid && tx_ready;
   assign tx_valid       = !fifo_empty;
   assign io_buffer_full = (fifo_count >= NEAR_FULL);

   byte_fifo #(
      .DEPTH_BITS (TX_DEPTH_BITS)
   ) u_tx_fifo (
      .clk        (clk_in),
      .rst_n      (rst_in),
      .push       (fifo_push),
      .push_data  (fifo_push_data),
      .pop        (fifo_pop),
      .head       (tx_data),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   always_ff @(posedge clk_in) begin
      if (ram_we) ram[mem_a[ADDR_BITS-1:0]] <= cpu_dout;
   end

   // Counter bytes 1-3 come from the snapshot taken at the byte-0 read, keeping the dword coherent.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mem_din      <= 8'h00;
         cycle_cnt    <= 32'h0;
         cnt_snap     <= '0;
         program_stop <= 1'b0;
         tx_overflow  <= 1'b0;
      end else begin
         if (rdy_in) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (!mem_wr) begin
               case (acc)
                  ACC_RAM, ACC_OOB: mem_din <= oob ? 8'h00 : ram[mem_a[ADDR_BITS-1:0]];
                  ACC_UART:         mem_din <= rx_valid ? rx_data : 8'h00;
                  ACC_CNT0: begin
                     mem_din  <= cycle_cnt[7:0];
                     cnt_snap <= cycle_cnt[31:8];
                  end
                  ACC_CNT_HI: begin
                     case (addr[1:0])
                        2'd1:    mem_din <= cnt_snap[15:8];
                        2'd2:    mem_din <= cnt_snap[23:16];
                        default: mem_din <= cnt_snap[31:24];
                     endcase
                  end
                  default:          mem_din <= 8'h00;
               endcase
            end else if (acc == ACC_CNT0) begin
               program_stop <= 1'b1;
            end
         end
         if (fifo_push && fifo_full && !fifo_pop) tx_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with read and TX scoreboards.
`timescale 1ns/1ps
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        program_stop;
   logic        tx_overflow;
   logic        bus_err;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  rd_exp_q[$];
   string       rd_tag_q[$];
   logic [7:0]  tx_exp_q[$];
   int          tx_seen = 0;
   logic [31:0] model_cnt;

   mem_io_responder dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .cpu_dout       (cpu_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_pop         (rx_pop),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .program_stop   (program_stop),
      .tx_overflow    (tx_overflow),
      .bus_err        (bus_err)
   );

   always #5 clk_in = ~clk_in;

   // Reference cycle counter: counts every edge with rdy_in high since reset.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)     model_cnt <= 32'h0;
      else if (rdy_in) model_cnt <= model_cnt + 32'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every byte the UART accepts must match the next queued expectation.
   always @(negedge clk_in) begin
      if (rst_in && tx_valid && tx_ready) begin
         tx_seen++;
         if (tx_exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("[TB] FAIL tx_unexpected: observed 0x%0h expected no byte", tx_data);
         end else begin
            check("tx_data", {24'h0, tx_data}, {24'h0, tx_exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_idle();
      mem_a    = 32'h0003_000C;
      mem_wr   = 1'b1;
      cpu_dout = 8'h00;
   endtask

   task automatic idle(input int n);
      set_idle();
      repeat (n) tick();
   endtask

   task automatic apply_write(input logic [31:0] a, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = 1'b1;
      cpu_dout = d;
      tick();
   endtask

   task automatic check_output();
      logic [7:0] exp;
      string      tag;
      exp = rd_exp_q.pop_front();
      tag = rd_tag_q.pop_front();
      check(tag, {24'h0, mem_din}, {24'h0, exp});
   endtask

   task automatic apply_read(input logic [31:0] a, input logic [7:0] exp, input string tag);
      rd_exp_q.push_back(exp);
      rd_tag_q.push_back(tag);
      mem_a  = a;
      mem_wr = 1'b0;
      tick();
      check_output();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] snap;
      int          base;
      int          guard;

      set_idle();
      rst_in   = 1'b0;
      rdy_in   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      #12;
      check("rst_mem_din",      {24'h0, mem_din}, 32'h0);
      check("rst_rx_pop",       {31'h0, rx_pop}, 32'h0);
      check("rst_program_stop", {31'h0, program_stop}, 32'h0);
      check("rst_tx_overflow",  {31'h0, tx_overflow}, 32'h0);
      check("rst_bus_err",      {31'h0, bus_err}, 32'h0);
      check("rst_tx_valid",     {31'h0, tx_valid}, 32'h0);
      check("rst_io_full",      {31'h0, io_buffer_full}, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;
      rdy_in = 1'b1;

      $display("[TB] RAM round-trip");
      apply_write(32'h0000_0010, 8'hA5);
      apply_read(32'h0000_0010, 8'hA5, "ram_rd_a5");
      apply_write(32'h0000_0011, 8'h77);
      check("ram_wr_holds_din", {24'h0, mem_din}, 32'hA5);
      apply_read(32'h0000_0011, 8'h77, "ram_rd_77");
      apply_read(32'h0000_0010, 8'hA5, "ram_b2b_0");
      apply_read(32'h0000_0011, 8'h77, "ram_b2b_1");

      $display("[TB] UART input");
      rx_valid = 1'b1;
      rx_data  = 8'h37;
      rd_exp_q.push_back(8'h37);
      rd_tag_q.push_back("rx_rd_37");
      mem_a  = 32'h0003_0000;
      mem_wr = 1'b0;
      #1;
      check("rx_pop_high", {31'h0, rx_pop}, 32'h1);
      tick();
      check_output();
      rx_valid = 1'b0;
      #1;
      check("rx_pop_low", {31'h0, rx_pop}, 32'h0);
      rd_exp_q.push_back(8'h00);
      rd_tag_q.push_back("rx_rd_empty");
      tick();
      check_output();
      rdy_in   = 1'b0;
      rx_valid = 1'b1;
      #1;
      check("rx_pop_rdy_low", {31'h0, rx_pop}, 32'h0);
      tick();
      check("din_hold_rdy_low", {24'h0, mem_din}, 32'h0);
      rdy_in   = 1'b1;
      rx_valid = 1'b0;

      $display("[TB] UART output");
      base = tx_seen;
      tx_exp_q.push_back(8'h41);
      apply_write(32'h0003_0000, 8'h41);
      check("tx_valid_after_push", {31'h0, tx_valid}, 32'h1);
      apply_write(32'h0003_0000, 8'h00);
      idle(4);
      check("tx_one_byte", tx_seen - base, 32'd1);
      check("tx_idle_empty", {31'h0, tx_valid}, 32'h0);

      $display("[TB] full flag and overflow");
      tx_ready = 1'b0;
      base     = tx_seen;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) tx_exp_q.push_back(8'(i * 16 + 1));
         apply_write(32'h0003_0000, 8'(i * 16 + 1));
         check($sformatf("io_full_w%0d", i), {31'h0, io_buffer_full}, {31'h0, (i >= 7)});
         check($sformatf("overflow_w%0d", i), {31'h0, tx_overflow}, {31'h0, (i == 9)});
      end
      set_idle();
      rdy_in   = 1'b0;
      tx_ready = 1'b1;
      guard    = 0;
      while (tx_valid && guard < 30) begin
         tick();
         guard++;
      end
      check("tx_drain_done", {31'h0, tx_valid}, 32'h0);
      check("tx_drained_8", tx_seen - base, 32'd8);
      check("overflow_sticky", {31'h0, tx_overflow}, 32'h1);
      rdy_in = 1'b1;

      $display("[TB] reset and counter coherence");
      rst_in = 1'b0;
      #2;
      check("rst2_overflow", {31'h0, tx_overflow}, 32'h0);
      check("rst2_mem_din", {24'h0, mem_din}, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;
      idle(300);
      guard = 0;
      while (model_cnt[7:0] != 8'hFF && guard < 300) begin
         tick();
         guard++;
      end
      snap = model_cnt;
      apply_read(32'h0003_0004, snap[7:0],   "cnt_b0");
      apply_read(32'h0003_0005, snap[15:8],  "cnt_b1");
      apply_read(32'h0003_0006, snap[23:16], "cnt_b2");
      apply_read(32'h0003_0007, snap[31:24], "cnt_b3");
      set_idle();
      rdy_in = 1'b0;
      repeat (5) tick();
      rdy_in = 1'b1;
      snap   = model_cnt;
      apply_read(32'h0003_0004, snap[7:0], "cnt_hold_b0");
      apply_read(32'h0003_0005, snap[15:8], "cnt_hold_b1");

      $display("[TB] program stop and bounds");
      apply_write(32'h0000_0004, 8'h5A);
      apply_write(32'h0000_0005, 8'h6B);
      base = tx_seen;
      tx_exp_q.push_back(8'h00);
      apply_write(32'h0003_0004, 8'h5A);
      check("program_stop_set", {31'h0, program_stop}, 32'h1);
      check("stop_tx_valid", {31'h0, tx_valid}, 32'h1);
      idle(3);
      check("stop_tx_one", tx_seen - base, 32'd1);
      check("program_stop_sticky", {31'h0, program_stop}, 32'h1);
`ifdef MEM_IO_BOUNDS_CHECK_EN
      apply_read(32'h0002_0004, 8'h00, "oob_rd_zero");
      check("bus_err_set", {31'h0, bus_err}, 32'h1);
      apply_write(32'h0002_0005, 8'h22);
      apply_read(32'h0000_0005, 8'h6B, "oob_wr_dropped");
`else
      apply_read(32'h0002_0004, 8'h5A, "alias_rd");
      check("bus_err_tied", {31'h0, bus_err}, 32'h0);
      apply_write(32'h0002_0005, 8'h22);
      apply_read(32'h0000_0005, 8'h22, "alias_wr");
`endif

      idle(5);
      check("tx_exp_drained", tx_exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Target-side responder for the CPU's byte-wide memory bus, i.e. the far end of `mem_a` / `mem_dout` / `mem_wr` / `mem_din` / `io_buffer_full`. It holds a 128 KB byte RAM and decodes the I/O window at `0x30000`:
- UART input byte read
- UART output byte write through a TX FIFO
- 32-bit cycle counter read
- program-stop write

It sits between the CPU core and the UART/host-interface logic on the board top level.

## Interface
Parameters:
- `ADDR_BITS`, default 17: RAM address width; 2^17 bytes.
- `TX_DEPTH_BITS`, default 3: TX FIFO holds 2^3 = 8 bytes.

Ports:
- `clk_in`, in, 1: the single clock.
- `rst_in`, in, 1: reset, asynchronous, active-low.
- `rdy_in`, in, 1: global ready; when low, no bus transaction is accepted and the counter holds.
- `mem_a`, in, 32: byte address from the CPU. Only bits 17:0 are decoded.
- `mem_wr`, in, 1: 1 means write, 0 means read.
- `cpu_dout`, in, 8: write data from the CPU.
- `mem_din`, out, 8: registered read data to the CPU.
- `io_buffer_full`, out, 1: TX FIFO nearly full.
- `rx_data`, in, 8: UART received byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_pop`, out, 1: one-cycle pulse; consumes `rx_data`.
- `tx_data`, out, 8: FIFO head byte.
- `tx_valid`, out, 1: FIFO is non-empty.
- `tx_ready`, in, 1: UART accepts `tx_data` this cycle.
- `program_stop`, out, 1: sticky; set by a write to `0x30004`.
- `tx_overflow`, out, 1: sticky; a byte was dropped because the FIFO was full.
- `bus_err`, out, 1: sticky; an out-of-range access occurred (only with the configuration macro).

## Operation
- **Decode.**
  - `mem_a[17:16] == 2'b11` selects I/O.
  - Any other value selects RAM, indexed by `mem_a[ADDR_BITS-1:0]`.
- **RAM read.** `mem_din <= ram[a]` on the next edge.
- **RAM write.** `ram[a] <= cpu_dout`; `mem_din` holds its value.
- **I/O read at `0x30000`.**
  - If `rx_valid`: `mem_din <= rx_data` and `rx_pop` pulses for one cycle, in the same cycle as the access.
  - Otherwise: `mem_din <= 0` and `rx_pop` stays low.
- **I/O read at `0x30004`–`0x30007`.**
  - A read of `0x30004` latches `cycle_cnt` into `cnt_snap` and returns byte 0 of the live value.
  - Reads of `0x30005`, `0x30006`, `0x30007` return `cnt_snap` bytes 1, 2, 3. This keeps the dword coherent.
- **I/O write at `0x30000`.** Pushes `cpu_dout` into the TX FIFO. A value of `0x00` is ignored.
- **I/O write at `0x30004`.** Pushes `0x00` and sets `program_stop`.
- **Other I/O addresses.** Reads return 0; writes have no effect.
- **Cycle counter.** `cycle_cnt` is 32 bits and increments by 1 on every edge where `rdy_in` is high. It wraps from `0xFFFFFFFF` to 0.
- **TX FIFO.**
  - Pop happens when `tx_valid && tx_ready`.
  - A push while `count == 2^TX_DEPTH_BITS` with no pop in the same cycle drops the byte and sets `tx_overflow`.
  - A push and pop in the same cycle are both performed, including when the FIFO is full; `count` is then unchanged.
  - Pointers wrap modulo the FIFO depth. `count` is `TX_DEPTH_BITS+1` bits wide.
- **Full flag.** `io_buffer_full = (count >= 2^TX_DEPTH_BITS - 1)`, combinational. This leaves one slot free for a write already in flight.

## Timing
- **Reset (`rst_in` low) clears all of the following immediately:**
  - outputs `mem_din`, `rx_pop`, `program_stop`, `tx_overflow`, `bus_err` go to 0;
  - internal state: FIFO pointers, `count`, `cycle_cnt` and `cnt_snap` go to 0;
  - consequently `tx_valid` = 0 and `io_buffer_full` = 0.
  - RAM contents are not reset.
  - An access in flight during reset is lost.
- **Read latency.** Exactly 1 cycle: the address is presented at edge N and data is valid after edge N+1. Back-to-back reads are sustained every cycle.
- **Write latency.** A write takes 1 cycle. A FIFO push is visible on `tx_valid` the cycle after the write edge.
- **`rdy_in` low.** Accesses are ignored. `mem_din`, `cycle_cnt` and `rx_pop` (forced to 0) hold. The FIFO still drains to the UART.
- **`tx_data`.** Driven combinationally from the FIFO head entry.

## Configuration
- **Macro `MEM_IO_BOUNDS_CHECK_EN`.**
  - Defined: a RAM-decoded address with `mem_a[17:0] >= 0x20000` (i.e. `0x20000`–`0x2FFFF`) sets `bus_err`. A read returns `0x00`; a write is dropped.
  - Undefined: the address is truncated to `ADDR_BITS` and aliases into the RAM. `bus_err` is tied to 0.

## Structure
- **Shared constants** go in the common constants header: `IO_BASE = 0x30000`, `IO_UART = 0x30000`, `IO_CLK_STOP = 0x30004`, and the `2'b11` I/O select value.
- **Sub-module `byte_fifo`.** A parameterised-depth 8-bit synchronous FIFO with push/pop, `count`, `full` and `empty`. It is instantiated once for TX.

## Test plan
1. **RAM round-trip.** Write `0xA5` to `0x00010`, then read `0x00010` → `mem_din` = `0xA5` one cycle after the read edge.
2. **UART output.** Write `0x41` to `0x30000`, then write `0x00` to `0x30000`, with `tx_ready` high → exactly one byte, `0x41`, on `tx_data`.
3. **Full flag and overflow.** Hold `tx_ready` low and write 9 non-zero bytes → `io_buffer_full` rises after the 7th write, the 9th byte is dropped and `tx_overflow` = 1.
4. **Counter coherence.** Reset, then hold `rdy_in` high for 300 cycles and read `0x30004`–`0x30007` on consecutive cycles → the assembled dword matches the counter value at the `0x30004` read edge, and byte 1 is not torn.
5. **Input read.** Read `0x30000` with `rx_valid` = 1 and `rx_data` = `0x37` → `mem_din` = `0x37` and a one-cycle `rx_pop`. Read again with `rx_valid` = 0 → `mem_din` = `0x00`.
6. **Program stop and bounds.** Write to `0x30004` → `program_stop` = 1 and `tx_data` = `0x00` is emitted. With `MEM_IO_BOUNDS_CHECK_EN` defined, a read of `0x20004` → `mem_din` = `0x00` and `bus_err` = 1.
